// File: rtl/prog_loader_if.sv
// Byte-stream input, instruction RAM write port and CPU release status for prog_loader.
// master = byte source / RAM / CPU side, slave = the loader.
interface prog_loader_if #(
    parameter int unsigned MEM_DEPTH = 256
) ();
    localparam int unsigned AW = $clog2(MEM_DEPTH);

    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_reset;
    logic          done;
    logic          error;

    modport master (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata, cpu_reset, done, error
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata, cpu_reset, done, error
    );
endinterface

// File: rtl/prog_loader.sv
// Loads a checksummed, length-prefixed byte image into instruction RAM word by word
// from address 0 and holds the CPU in reset until the image is verified.
module prog_loader #(
    parameter int unsigned MEM_DEPTH = 256
) (
    input logic         clk,
    input logic         reset,
    prog_loader_if.slave bus
);
    localparam int unsigned AW = $clog2(MEM_DEPTH);
    localparam int unsigned CW = 17;

    typedef enum logic [2:0] {
        HDR_HI,
        HDR_LO,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    nhi_q, nhi_d;
    logic [CW-1:0] nwords_q, nwords_d;
    logic [CW-1:0] wcnt_q, wcnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [1:0]    bidx_q, bidx_d;
    logic [23:0]   asm_q, asm_d;
    logic [7:0]    sum_q, sum_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic          in_ready_q, in_ready_d;
    logic          cpu_reset_q, cpu_reset_d;
    logic          done_q, done_d;
    logic          error_q, error_d;

    logic          accept;
    logic [15:0]   hdr_n;

    assign accept = bus.in_valid && in_ready_q;
    assign hdr_n  = {nhi_q, bus.in_data};

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= HDR_HI;
            nhi_q       <= '0;
            nwords_q    <= '0;
            wcnt_q      <= '0;
            addr_q      <= '0;
            bidx_q      <= '0;
            asm_q       <= '0;
            sum_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            in_ready_q  <= 1'b1;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            nhi_q       <= nhi_d;
            nwords_q    <= nwords_d;
            wcnt_q      <= wcnt_d;
            addr_q      <= addr_d;
            bidx_q      <= bidx_d;
            asm_q       <= asm_d;
            sum_q       <= sum_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            in_ready_q  <= in_ready_d;
            cpu_reset_q <= cpu_reset_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    // Next-state, datapath and output logic
    always_comb begin
        state_d     = state_q;
        nhi_d       = nhi_q;
        nwords_d    = nwords_q;
        wcnt_d      = wcnt_q;
        addr_d      = addr_q;
        bidx_d      = bidx_q;
        asm_d       = asm_q;
        sum_d       = sum_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            HDR_HI: begin
                if (accept) begin
                    nhi_d   = bus.in_data;
                    state_d = HDR_LO;
                end
            end
            HDR_LO: begin
                if (accept) begin
                    nwords_d = CW'(hdr_n);
                    wcnt_d   = '0;
                    addr_d   = '0;
                    bidx_d   = '0;
                    sum_d    = '0;
                    if (hdr_n == 16'd0) begin
                        state_d = CSUM;
                    end else if (32'(hdr_n) > MEM_DEPTH) begin
                        state_d = ERR;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    sum_d  = sum_q + bus.in_data;
                    bidx_d = bidx_q + 2'd1;
                    asm_d  = {asm_q[15:0], bus.in_data};
                    // Fourth byte completes the word; the first three live in asm_q
                    if (bidx_q == 2'd3) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = addr_q;
                        mem_wdata_d = {asm_q, bus.in_data};
                        addr_d      = addr_q + AW'(1);
                        wcnt_d      = wcnt_q + CW'(1);
                        if ((wcnt_q + CW'(1)) == nwords_q) begin
                            state_d = CSUM;
                        end
                    end
                end
            end
            CSUM: begin
                if (accept) begin
                    state_d = (bus.in_data == sum_q) ? DONE : ERR;
                end
            end
            DONE, ERR: begin
                state_d = state_q;
            end
            default: begin
                state_d = ERR;
            end
        endcase

        in_ready_d  = (state_d != DONE) && (state_d != ERR);
        cpu_reset_d = (state_d != DONE);
        done_d      = (state_d == DONE);
        error_d     = (state_d == ERR);
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.cpu_reset = cpu_reset_q;
    assign bus.done      = done_q;
    assign bus.error     = error_q;
endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: expected RAM writes go to a queue as bytes are sent
// and are matched (address, data, cycle) when mem_we appears.
module tb_prog_loader;
    localparam int unsigned MEM_DEPTH = 256;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    logic [31:0] ram [MEM_DEPTH];
    logic [31:0] img [2];

    prog_loader_if #(.MEM_DEPTH(MEM_DEPTH)) bus ();

    prog_loader #(.MEM_DEPTH(MEM_DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Write-port monitor: every mem_we must match the oldest expected write
    always @(negedge clk) begin
        if (reset) begin
            for (int i = 0; i < MEM_DEPTH; i++) ram[i] = 32'h0;
        end
        if (bus.mem_we) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL spurious_write observed addr=%0h data=%0h expected no write", bus.mem_addr, bus.mem_wdata);
            end
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                checks++;
                assert (bus.mem_addr === e.addr) else begin
                    errors++;
                    $error("FAIL wr_addr observed=%0h expected=%0h", bus.mem_addr, e.addr);
                end
                checks++;
                assert (bus.mem_wdata === e.data) else begin
                    errors++;
                    $error("FAIL wr_data observed=%0h expected=%0h", bus.mem_wdata, e.data);
                end
                checks++;
                assert (cyc === e.cyc) else begin
                    errors++;
                    $error("FAIL wr_cycle observed=%0d expected=%0d", cyc, e.cyc);
                end
            end
            ram[bus.mem_addr] = bus.mem_wdata;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            bus.in_valid = 1'b0;
            bus.in_data  = 8'($urandom);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        if (gap) idle(1 + $urandom_range(0, 2));
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Sends the first nbytes data bytes of img, queuing a write after each 4th byte
    task automatic send_data(input int nbytes, input bit gap);
        for (int i = 0; i < nbytes; i++) begin
            logic [31:0] w;
            exp_t e;
            w = img[i / 4];
            send_byte(w[31 - 8 * (i % 4) -: 8], gap);
            if (i % 4 == 3) begin
                e.addr = 8'(i / 4);
                e.data = w;
                e.cyc  = cyc;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic drain(input string tag);
        idle(3);
        chk(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        img[0] = 32'h2010002A;
        img[1] = 32'h20110058;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_cpu_reset", 32'(bus.cpu_reset), 32'd1);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_error", 32'(bus.error), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);

        // Two-word image, contiguous
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_data(8, 0);
        chk("t1_done_before_csum", 32'(bus.done), 32'd0);
        send_byte(8'hE3, 0);
        chk("t1_done", 32'(bus.done), 32'd1);
        chk("t1_cpu_reset", 32'(bus.cpu_reset), 32'd0);
        chk("t1_error", 32'(bus.error), 32'd0);
        chk("t1_in_ready", 32'(bus.in_ready), 32'd0);
        drain("t1_drain");
        chk("t1_ram0", ram[0], 32'h2010002A);
        chk("t1_ram1", ram[1], 32'h20110058);

        // Bad checksum
        do_reset();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_data(8, 0);
        send_byte(8'hE4, 0);
        chk("t2_error", 32'(bus.error), 32'd1);
        chk("t2_done", 32'(bus.done), 32'd0);
        chk("t2_cpu_reset", 32'(bus.cpu_reset), 32'd1);
        chk("t2_in_ready", 32'(bus.in_ready), 32'd0);
        send_byte(8'h55, 0);
        chk("t2_error_sticky", 32'(bus.error), 32'd1);
        drain("t2_drain");

        // Empty images
        do_reset();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        chk("t3_done", 32'(bus.done), 32'd1);
        chk("t3_error", 32'(bus.error), 32'd0);
        do_reset();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        chk("t3b_error", 32'(bus.error), 32'd1);
        chk("t3b_done", 32'(bus.done), 32'd0);
        drain("t3_drain");

        // Oversize header (257 words)
        do_reset();
        send_byte(8'h01, 0);
        chk("t4_error_early", 32'(bus.error), 32'd0);
        send_byte(8'h01, 0);
        chk("t4_error", 32'(bus.error), 32'd1);
        chk("t4_in_ready", 32'(bus.in_ready), 32'd0);
        for (int i = 0; i < 8; i++) send_byte(8'($urandom), 0);
        chk("t4_cpu_reset", 32'(bus.cpu_reset), 32'd1);
        drain("t4_drain");

        // Two-word image with gaps in in_valid
        do_reset();
        send_byte(8'h00, 1);
        send_byte(8'h02, 1);
        send_data(8, 1);
        send_byte(8'hE3, 1);
        chk("t5_done", 32'(bus.done), 32'd1);
        chk("t5_cpu_reset", 32'(bus.cpu_reset), 32'd0);
        drain("t5_drain");
        chk("t5_ram0", ram[0], 32'h2010002A);
        chk("t5_ram1", ram[1], 32'h20110058);

        // Reset on the edge that accepts a 4th byte: write suppressed
        do_reset();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_data(3, 0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h2A;
        reset        = 1'b1;
        @(posedge clk);
        #1;
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        chk("t6_we_suppressed", 32'(bus.mem_we), 32'd0);
        chk("t6_in_ready", 32'(bus.in_ready), 32'd1);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_data(4, 0);
        send_byte(8'h5A, 0);
        chk("t6_done", 32'(bus.done), 32'd1);
        drain("t6_drain");

        // Reset after 6 data bytes, then full resend
        do_reset();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_data(6, 0);
        do_reset();
        chk("t7_mid_done", 32'(bus.done), 32'd0);
        chk("t7_mid_in_ready", 32'(bus.in_ready), 32'd1);
        chk("t7_one_write", 32'(exp_q.size()), 32'd0);
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_data(8, 0);
        send_byte(8'hE3, 0);
        chk("t7_done", 32'(bus.done), 32'd1);
        chk("t7_error", 32'(bus.error), 32'd0);
        drain("t7_drain");
        chk("t7_ram0", ram[0], 32'h2010002A);
        chk("t7_ram1", ram[1], 32'h20110058);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
